// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, fetches one word per cycle into a
// two-entry FIFO and hands it to decode over valid/ready. Redirects flush the
// FIFO. Fetch stops after a HALT opcode is enqueued.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [5:0]  HALT_OP  = 6'b111111,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_ins,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushes
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t            r_state;
  logic [31:0]       r_pc;
  logic              r_halted;
  logic [31:0]       r_fifo_ins [DEPTH];
  logic [31:0]       r_fifo_pc  [DEPTH];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [CntW-1:0]   r_count;

  logic w_pop;
  logic w_push;
  logic w_flush;
  logic w_is_halt;

  assign ins_valid = (r_count != '0);
  assign w_pop     = ins_valid & ins_ready;
  // Redirect wins over everything once the sequencer has been started.
  assign w_flush   = redirect & (r_state != IDLE);
  // A full FIFO may still accept a word when the head leaves this same cycle.
  assign w_push    = (r_state == RUN) & ~redirect & ((r_count < CntW'(DEPTH)) | w_pop);
  assign w_is_halt = (imem_ins[31:26] == HALT_OP);

  assign imem_addr = r_pc;
  assign ins_out   = r_fifo_ins[r_rptr];
  assign pc_out    = r_fifo_pc[r_rptr];
  assign halted    = r_halted;

  // Sequencer FSM and program counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // PC may be preloaded while idle, but fetching waits for start.
          if (redirect) r_pc <= redirect_pc;
          if (start) r_state <= RUN;
        end
        RUN: begin
          if (redirect) begin
            r_pc <= redirect_pc;
          end else if (w_push) begin
            r_pc <= r_pc + 32'd1;
            if (w_is_halt) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end
          end
        end
        HALT: begin
          if (redirect) begin
            r_pc     <= redirect_pc;
            r_state  <= RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // Instruction FIFO: storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_ins <= '{default: '0};
      r_fifo_pc  <= '{default: '0};
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else if (w_flush) begin
      // Any same-cycle pop is dropped along with the buffered words.
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo_ins[r_wptr] <= imem_ins;
        r_fifo_pc[r_wptr]  <= r_pc;
        r_wptr             <= r_wptr + PtrW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushes;
  logic        w_flush_cnt;

  // A redirect counts if it throws away buffered work or interrupts fetching.
  assign w_flush_cnt  = w_flush & ((r_state == RUN) | (r_count != '0));
  assign perf_fetched = r_perf_fetched;
  assign perf_flushes = r_perf_flushes;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_push && (r_perf_fetched != 32'hFFFF_FFFF)) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_flush_cnt && (r_perf_flushes != 32'hFFFF_FFFF)) begin
        r_perf_flushes <= r_perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule
